// File: rtl/mux4_rr_sel_arbiter.sv
// Round-robin 4-way grant with hold timer; drives the 4:1 mux select, 1-cycle req->grant latency.
// No backpressure: the holder keeps the path until done, request drop or HOLD_MAX expiry.
module mux4_rr_sel_arbiter #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [3:0] grant,
  output logic       valid
);

  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;

  logic       release_now;
  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] win;
  logic       hit;

  // On release the search starts just past the holder, so it becomes lowest priority.
  always_comb begin
    release_now = (state == GRANT) && (done || !req[sel] || (cnt == HOLD_LIM));
    base        = release_now ? sel + 2'd1 : ptr;
    hit         = 1'b0;
    win         = base;
    idx         = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (req[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
      sel   <= 2'd0;
      grant <= 4'b0000;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state <= GRANT;
            sel   <= win;
            grant <= 4'b0001 << win;
            valid <= 1'b1;
            cnt   <= 8'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr <= sel + 2'd1;
            if (hit) begin
              sel   <= win;
              grant <= 4'b0001 << win;
              cnt   <= 8'd1;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
              grant <= 4'b0000;
            end
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_sel_arbiter.sv
// Bench for mux4_rr_sel_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_mux4_rr_sel_arbiter;

  localparam int HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;

  int n_checks;
  int n_fail;

  // Reference state: who holds the path, for how long, and who is first in line next.
  int m_ptr;
  int m_sel;
  int m_hold;
  bit m_valid;

  mux4_rr_sel_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .sel(sel), .grant(grant), .valid(valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [6:0] m_out();
    logic [3:0] g;
    g = m_valid ? 4'(1 << m_sel) : 4'b0000;
    return {m_valid, 2'(m_sel), g};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_hold = 0; m_valid = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    int w;
    if (!m_valid) begin
      w = pick(m_ptr, r);
      if (w >= 0) begin m_sel = w; m_valid = 1; m_hold = 1; end
    end else if (d || !r[m_sel] || m_hold >= HOLD) begin
      m_ptr = (m_sel + 1) % 4;
      w = pick(m_ptr, r);
      if (w >= 0) begin m_sel = w; m_hold = 1; end
      else m_valid = 0;
    end else begin
      m_hold++;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, update model, land at edge+1.
  task automatic step(input logic [3:0] r, input logic d);
    req = r; done = d;
    @(posedge clk);
    model_step(r, d);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; done = 1'b0;
    #1;
    n_checks++;
    if ({valid, sel, grant} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b sel=%0d grant=%b, want 0/0/0000", valid, sel, grant);
    end
    rst = 1'b0;
    model_reset();
    step(4'b1111, 1'b0);
    n_checks++;
    if ({valid, sel, grant} !== {1'b1, 2'd0, 4'b0001}) begin
      n_fail++;
      $display("FAIL reset_first_grant: got valid=%b sel=%0d grant=%b, want 1/0/0001", valid, sel, grant);
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step(4'b0001, 1'b0);
      n_checks++;
      if ({valid, sel, grant} !== {1'b1, 2'd0, 4'b0001} || {valid, sel, grant} !== m_out()) begin
        n_fail++;
        $display("FAIL single_req cycle %0d: got valid=%b sel=%0d grant=%b, want 1/0/0001", c, valid, sel, grant);
      end
    end
  endtask

  task automatic test_contention();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(4'b1111, 1'b1);
      n_checks++;
      if (valid !== 1'b1 || sel !== 2'(exp_seq[c]) || grant !== 4'(1 << exp_seq[c])) begin
        n_fail++;
        $display("FAIL contention cycle %0d: got valid=%b sel=%0d grant=%b, want 1/%0d", c, valid, sel, grant, exp_seq[c]);
      end
    end
  endtask

  task automatic test_timeout();
    logic [3:0] exp_g;
    do_reset();
    for (int c = 1; c <= 3 * HOLD; c++) begin
      step(4'b0101, 1'b0);
      exp_g = (((c - 1) / HOLD) % 2 == 1) ? 4'b0100 : 4'b0001;
      n_checks++;
      if (valid !== 1'b1 || grant !== exp_g) begin
        n_fail++;
        $display("FAIL timeout_rotation cycle %0d: got valid=%b grant=%b, want 1/%b", c, valid, grant, exp_g);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    for (int c = 1; c <= 3; c++) begin
      step(4'b0010, 1'b0);
      n_checks++;
      if ({valid, sel, grant} !== {1'b1, 2'd1, 4'b0010}) begin
        n_fail++;
        $display("FAIL drop_hold cycle %0d: got valid=%b sel=%0d grant=%b, want 1/1/0010", c, valid, sel, grant);
      end
    end
    for (int c = 0; c < 2; c++) begin
      step(4'b0000, 1'b1);
      n_checks++;
      if ({valid, sel, grant} !== {1'b0, 2'd1, 4'b0000}) begin
        n_fail++;
        $display("FAIL drop_release cycle %0d: got valid=%b sel=%0d grant=%b, want 0/1/0000", c, valid, sel, grant);
      end
    end
  endtask

  task automatic test_async_reset();
    time t0;
    do_reset();
    step(4'b0100, 1'b0);
    n_checks++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL async_setup: got grant=%b, want 0100", grant);
    end
    #2;
    t0 = $time;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({valid, sel, grant} !== 7'b0 || ($time - t0) >= 5) begin
      n_fail++;
      $display("FAIL async_clear: got valid=%b sel=%0d grant=%b, want 0/0/0000 before edge", valid, sel, grant);
    end
    rst = 1'b0;
    model_reset();
    step(4'b1100, 1'b0);
    n_checks++;
    if ({valid, sel, grant} !== {1'b1, 2'd2, 4'b0100}) begin
      n_fail++;
      $display("FAIL async_restart: got valid=%b sel=%0d grant=%b, want 1/2/0100", valid, sel, grant);
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      d = ($urandom_range(0, 3) == 0);
      step(r, d);
      n_checks++;
      if ({valid, sel, grant} !== m_out()) begin
        n_fail++;
        $display("FAIL random cycle %0d req=%b done=%b: got valid=%b sel=%0d grant=%b, want %b",
                 c, r, d, valid, sel, grant, m_out());
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1; req = 4'b0000; done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_drop();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
